// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared constants for the 800x600 display pipeline and the
//               state encoding / helpers used by vblank_arbiter.
//               H_ACTIVE/V_ACTIVE/H_TOTAL/V_TOTAL : 800x600 @ 40 MHz timing
//               OWNER_W                           : width of owner/pointer
//               arb_state_e                       : IDLE / ARB / GRANT
//               next_idx()                        : owner+1 modulo N
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int H_TOTAL  = 1056;
    localparam int V_TOTAL  = 628;

    // Owner index is always 3 bits wide so up to 8 requesters fit.
    localparam int OWNER_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_GRANT = 2'd2
    } arb_state_e;

    // Round-robin successor: wraps to 0 after the last requester.
    function automatic logic [OWNER_W-1:0] next_idx(input logic [OWNER_W-1:0] idx,
                                                    input int                 n);
        if (int'(idx) >= n - 1) begin
            next_idx = '0;
        end else begin
            next_idx = idx + 1'b1;
        end
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vblank_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin priority search. Starting at ptr
//               and wrapping modulo N_REQ, returns the first asserted request.
//   req   in  N_REQ   request vector
//   ptr   in  3       first index to consider (always < N_REQ)
//   valid out 1       at least one request is asserted
//   idx   out 3       index of the winning request (0 when !valid)
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import vga_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]   req,
    input  logic [OWNER_W-1:0] ptr,
    output logic               valid,
    output logic [OWNER_W-1:0] idx
);

    // Rotating the doubled vector right by ptr puts requester ptr at bit 0,
    // so a plain lowest-bit-first search implements the wrap-around order.
    logic [2*N_REQ-1:0] w_dbl;
    logic [N_REQ-1:0]   w_rot;
    logic [OWNER_W-1:0] w_off;
    logic [OWNER_W:0]   w_sum;

    assign w_dbl = {req, req};
    assign w_rot = w_dbl[N_REQ-1:0] == '0 ? '0 : N_REQ'(w_dbl >> ptr);

    always_comb begin
        valid = 1'b0;
        w_off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                valid = 1'b1;
                w_off = OWNER_W'(j);
            end
        end
    end

    // Undo the rotation: (ptr + offset) modulo N_REQ.
    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (OWNER_W+1)'(N_REQ)) begin
            w_sum = w_sum - (OWNER_W+1)'(N_REQ);
        end
        idx = valid ? w_sum[OWNER_W-1:0] : '0;
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/vblank_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vblank_arbiter
// Description : Grants round-robin access to shared drawing-state registers
//               only while vertical blanking is active, so updates never tear
//               a visible frame. Also produces a frame-start pulse and a
//               wrapping frame counter.
//   pclk        in   1       pixel clock
//   reset       in   1       asynchronous active-low reset
//   vblnk_in    in   1       vertical blanking from the timing chain
//   req         in   N_REQ   per-requester request, held until own done
//   done        in   N_REQ   per-requester single-cycle release pulse
//   grant       out  N_REQ   registered one-hot grant, zero when no owner
//   owner_id    out  3       index of current/last owner
//   window_open out  1       registered vblnk_in
//   frame_start out  1       one-cycle pulse after vblank rising edge
//   frame_cnt   out  FCNT_W  frames since reset, wraps
//   timeout     out  1       one-cycle pulse, grant revoked after MAX_GRANT
//   abort       out  1       one-cycle pulse, grant revoked by end of vblank
// Revision    : 1.0 - initial release
// ============================================================================
module vblank_arbiter
    import vga_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int MAX_GRANT = 256,
    parameter int FCNT_W    = 16
) (
    input  logic              pclk,
    input  logic              reset,
    input  logic              vblnk_in,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  done,
    output logic [N_REQ-1:0]  grant,
    output logic [2:0]        owner_id,
    output logic              window_open,
    output logic              frame_start,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              timeout,
    output logic              abort
);

    localparam int               TMR_W    = $clog2(MAX_GRANT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MAX_GRANT - 1);

    arb_state_e          state_q, state_d;
    logic                vblnk_q;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [OWNER_W-1:0]  owner_q, owner_d;
    logic [OWNER_W-1:0]  ptr_q, ptr_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                frame_start_q, frame_start_d;
    logic [FCNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic                timeout_q, timeout_d;
    logic                abort_q, abort_d;

    logic                w_rise;
    logic                w_fall;
    logic                w_owner_done;
    logic                w_pick_valid;
    logic [OWNER_W-1:0]  w_pick_idx;

    assign w_rise = vblnk_in & ~vblnk_q;
    assign w_fall = ~vblnk_in & vblnk_q;

    // grant_q is one-hot on the owner while in GRANT, so masking done with it
    // selects the owner's bit and ignores everyone else's.
    assign w_owner_done = |(done & grant_q);

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (w_pick_valid),
        .idx   (w_pick_idx)
    );

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        owner_d       = owner_q;
        ptr_d         = ptr_q;
        timer_d       = timer_q;
        timeout_d     = 1'b0;
        abort_d       = 1'b0;
        frame_start_d = w_rise;
        frame_cnt_d   = frame_cnt_q + FCNT_W'(w_rise);

        case (state_q)
            ST_IDLE: begin
                grant_d = '0;
                if (w_rise) begin
                    state_d = ST_ARB;
                end
            end

            ST_ARB: begin
                if (!vblnk_in) begin
                    state_d = ST_IDLE;
                end else if (w_pick_valid) begin
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick_idx;
                    owner_d = w_pick_idx;
                    timer_d = '0;
                    state_d = ST_GRANT;
                end
            end

            ST_GRANT: begin
                // A vblank rise here can only be a glitch; it is ignored.
                if (w_owner_done) begin
                    // Release on the fall cycle is clean: no abort pulse.
                    grant_d = '0;
                    ptr_d   = next_idx(owner_q, N_REQ);
                    state_d = w_fall ? ST_IDLE : ST_ARB;
                end else if (w_fall) begin
                    grant_d = '0;
                    abort_d = 1'b1;
                    ptr_d   = next_idx(owner_q, N_REQ);
                    state_d = ST_IDLE;
                end else if (timer_q == TMR_LAST) begin
                    grant_d   = '0;
                    timeout_d = 1'b1;
                    ptr_d     = next_idx(owner_q, N_REQ);
                    state_d   = ST_ARB;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            vblnk_q       <= 1'b0;
            grant_q       <= '0;
            owner_q       <= '0;
            ptr_q         <= '0;
            timer_q       <= '0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
            timeout_q     <= 1'b0;
            abort_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            vblnk_q       <= vblnk_in;
            grant_q       <= grant_d;
            owner_q       <= owner_d;
            ptr_q         <= ptr_d;
            timer_q       <= timer_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            timeout_q     <= timeout_d;
            abort_q       <= abort_d;
        end
    end

    assign grant       = grant_q;
    assign owner_id    = owner_q;
    assign window_open = vblnk_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;
    assign timeout     = timeout_q;
    assign abort       = abort_q;

endmodule : vblank_arbiter
`default_nettype wire

// File: tb/tb_vblank_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_vblank_arbiter
// Description : Randomized self-checking bench for vblank_arbiter. Requesters
//               and a compressed vblank schedule are generated with $urandom;
//               a transaction-level model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vblank_arbiter;

    localparam int N_REQ     = 4;
    localparam int IW        = 2;
    localparam int MAX_GRANT = 256;
    localparam int FCNT_W    = 5;

    logic              pclk     = 1'b0;
    logic              reset    = 1'b0;
    logic              vblnk_in = 1'b0;
    logic [N_REQ-1:0]  req      = '0;
    logic [N_REQ-1:0]  done     = '0;
    logic [N_REQ-1:0]  grant;
    logic [2:0]        owner_id;
    logic              window_open;
    logic              frame_start;
    logic [FCNT_W-1:0] frame_cnt;
    logic              timeout;
    logic              abort;

    vblank_arbiter #(
        .N_REQ     (N_REQ),
        .MAX_GRANT (MAX_GRANT),
        .FCNT_W    (FCNT_W)
    ) dut (
        .pclk        (pclk),
        .reset       (reset),
        .vblnk_in    (vblnk_in),
        .req         (req),
        .done        (done),
        .grant       (grant),
        .owner_id    (owner_id),
        .window_open (window_open),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt),
        .timeout     (timeout),
        .abort       (abort)
    );

    always #12.5 pclk = ~pclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: who holds the registers, whether this blanking
    // interval is still open for new grants, and how long the holder has
    // had them.
    // ------------------------------------------------------------------
    bit m_vq;
    bit m_open;
    int m_holder;
    int m_age;
    int m_next;
    int m_last;
    int m_fcnt;
    bit m_fs, m_to, m_ab;

    // Requester behaviour
    bit want [N_REQ];
    int cd   [N_REQ];

    // Compressed vblank schedule
    bit tb_vin;
    int sch_left;

    function automatic int new_delay();
        if ($urandom_range(9) < 2) return -1;
        return int'($urandom_range(20, 1));
    endfunction

    task automatic model_reset();
        m_vq = 0; m_open = 0; m_holder = -1; m_age = 0;
        m_next = 0; m_last = 0; m_fcnt = 0;
        m_fs = 0; m_to = 0; m_ab = 0;
    endtask

    task automatic model_step(input bit vin, input logic [N_REQ-1:0] rq,
                              input logic [N_REQ-1:0] dn);
        bit rise, fall;
        int k;
        rise = vin && !m_vq;
        fall = !vin && m_vq;
        m_fs = rise; m_to = 0; m_ab = 0;
        if (rise) m_fcnt = (m_fcnt + 1) % (1 << FCNT_W);
        if (m_holder >= 0) begin
            if (dn[m_holder[IW-1:0]]) begin
                m_next = (m_holder + 1) % N_REQ;
                m_holder = -1;
                m_open = !fall;
            end else if (fall) begin
                m_ab = 1;
                m_next = (m_holder + 1) % N_REQ;
                m_holder = -1;
                m_open = 0;
            end else if (m_age == MAX_GRANT - 1) begin
                m_to = 1;
                m_next = (m_holder + 1) % N_REQ;
                m_holder = -1;
                m_open = 1;
            end else begin
                m_age++;
            end
        end else if (m_open) begin
            if (!vin) begin
                m_open = 0;
            end else begin
                for (int i = 0; i < N_REQ; i++) begin
                    k = (m_next + i) % N_REQ;
                    if (rq[k[IW-1:0]]) begin
                        m_holder = k;
                        m_age = 0;
                        m_last = k;
                        cd[k[IW-1:0]] = new_delay();
                        break;
                    end
                end
            end
        end else if (rise) begin
            m_open = 1;
        end
        m_vq = vin;
    endtask

    task automatic compare_all();
        logic [31:0] eg;
        eg = (m_holder >= 0) ? (32'd1 << m_holder) : 32'd0;
        check("grant",       32'(grant),       eg);
        check("owner_id",    32'(owner_id),    32'(m_last));
        check("window_open", 32'(window_open), 32'(m_vq));
        check("frame_start", 32'(frame_start), 32'(m_fs));
        check("frame_cnt",   32'(frame_cnt),   32'(m_fcnt));
        check("timeout",     32'(timeout),     32'(m_to));
        check("abort",       32'(abort),       32'(m_ab));
    endtask

    // Choose this cycle's inputs, apply them, and advance the model.
    task automatic drive_step();
        logic [N_REQ-1:0] rq, dn;
        bit fall;
        int h;
        if (sch_left == 0) begin
            tb_vin = !tb_vin;
            if (tb_vin)
                sch_left = ($urandom_range(1) == 0) ? int'($urandom_range(80, 20))
                                                    : int'($urandom_range(600, 280));
            else
                sch_left = int'($urandom_range(40, 10));
        end
        sch_left--;
        fall = !tb_vin && m_vq;

        for (int r = 0; r < N_REQ; r++)
            if (!want[r] && $urandom_range(19) == 0) want[r] = 1;
        rq = '0;
        for (int r = 0; r < N_REQ; r++) rq[r] = want[r];

        dn = '0;
        h = m_holder;
        for (int r = 0; r < N_REQ; r++)
            if (r != h && $urandom_range(15) == 0) dn[r] = 1'b1;
        if (h >= 0) begin
            if (cd[h[IW-1:0]] == 0) begin
                dn[h[IW-1:0]] = 1'b1;
                want[h[IW-1:0]] = 0;
            end else if (cd[h[IW-1:0]] > 0) begin
                cd[h[IW-1:0]]--;
            end
            if (fall && $urandom_range(1) == 0) begin
                dn[h[IW-1:0]] = 1'b1;
                want[h[IW-1:0]] = 0;
            end
            if ($urandom_range(63) == 0) want[h[IW-1:0]] = 0;
        end

        vblnk_in = tb_vin;
        req      = rq;
        done     = dn;
        model_step(tb_vin, rq, dn);
    endtask

    task automatic do_reset(input int cyc);
        reset    = 1'b0;
        tb_vin   = 1'b0;
        vblnk_in = 1'b0;
        done     = '0;
        sch_left = int'($urandom_range(40, 10));
        model_reset();
        repeat (cyc) begin
            @(negedge pclk);
            compare_all();
        end
        reset = 1'b1;
        drive_step();
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            if (n_errors >= 20) break;
            @(negedge pclk);
            compare_all();
            drive_step();
        end
    endtask

    task automatic run_until_grant(input int limit);
        bit got;
        got = 0;
        for (int c = 0; c < limit; c++) begin
            @(negedge pclk);
            compare_all();
            if (m_holder >= 0) begin
                got = 1;
                break;
            end
            drive_step();
        end
        check("grant_wait", 32'(got), 32'd1);
    endtask

    initial begin
        for (int r = 0; r < N_REQ; r++) begin
            want[r] = 1;
            cd[r]   = 0;
        end
        req = '1;
        do_reset(5);
        run(20000);

        // Asynchronous reset while a grant is active.
        run_until_grant(5000);
        #3 reset = 1'b0;
        #1 check("async_clear", 32'(grant), 32'd0);
        do_reset(4);
        run(3000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_vblank_arbiter
`default_nettype wire
